// File: rtl/immgen_if.sv
// immgen_if: instruction-in / immediate-out bus for immgen_pipe.
//   in_valid/in_ready/in_instr/in_pc            : upstream instruction handshake
//   out_valid/out_ready                         : downstream result handshake
//   out_imm/out_fmt/out_target/out_illegal/out_pc : decoded result fields
// master drives instructions and consumes results; slave is the pipeline.
interface immgen_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal, out_pc
  );
endinterface

// File: rtl/immgen_pipe.sv
// immgen_pipe: two-stage pipelined RISC-V immediate generator.
// Stage 1 classifies the instruction format, builds the XLEN-wide immediate
// and flags illegal encodings; stage 2 adds the PC-relative target for
// branch, JAL and AUIPC. Full valid/ready backpressure, 1 instr/cycle.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : immgen_if.slave (instruction in, decoded result out)
// Parameter XLEN: 32 (RV32I) or 64 (RV64I).
// Optional feature macro IMMGEN_CSR_EN: when defined, CSRRWI/CSRRSI/CSRRCI
// produce fmt 7 with the zero-extended uimm; otherwise they decode as R.
module immgen_pipe #(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  immgen_if.slave bus
);

  localparam logic IS64 = (XLEN == 64);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
`ifdef IMMGEN_CSR_EN
  localparam logic [2:0] FMT_CSR   = 3'd7;
`endif

  function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  // fn is instr[31:25]; a right shift may set instr[30]; a 6-bit shamt owns instr[25].
  function automatic logic shift_bad(input logic [6:0] fn, input logic right, input logic wide);
    logic [6:0] f;
    f = fn;
    if (right) f[5] = 1'b0;
    if (wide)  f[0] = 1'b0;
    return |f;
  endfunction

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  assign instr = bus.in_instr;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];

  logic signed [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
  assign imm_i32 = {{20{instr[31]}}, instr[31:20]};
  assign imm_s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u32 = {instr[31:12], 12'b0};
  assign imm_j32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [XLEN-1:0] shamt5, shamt6;
  assign shamt5 = XLEN'(instr[24:20]);
  assign shamt6 = XLEN'(instr[25:20]);

  logic            s1_ready, s2_ready;
  logic            vld_p1_q, vld_p2_q;
  logic [XLEN-1:0] imm_p1_d, imm_p1_q, imm_p2_q;
  logic [2:0]      fmt_p1_d, fmt_p1_q, fmt_p2_q;
  logic            ill_p1_d, ill_p1_q, ill_p2_q;
  logic            tgt_en_p1_d, tgt_en_p1_q;
  logic [XLEN-1:0] pc_p1_q, pc_p2_q;
  logic [XLEN-1:0] tgt_p2_d, tgt_p2_q;

  assign s2_ready = !vld_p2_q || bus.out_ready;
  assign s1_ready = !vld_p1_q || s2_ready;

  always_comb begin
    imm_p1_d    = '0;
    fmt_p1_d    = FMT_R;
    ill_p1_d    = 1'b0;
    tgt_en_p1_d = 1'b0;
    case (opc)
      OPC_LUI: begin
        imm_p1_d = sext(imm_u32);
        fmt_p1_d = FMT_U;
      end
      OPC_AUIPC: begin
        imm_p1_d    = sext(imm_u32);
        fmt_p1_d    = FMT_U;
        tgt_en_p1_d = 1'b1;
      end
      OPC_JAL: begin
        imm_p1_d    = sext(imm_j32);
        fmt_p1_d    = FMT_J;
        tgt_en_p1_d = 1'b1;
      end
      OPC_JALR: begin
        if (f3 != 3'b000) ill_p1_d = 1'b1;
        else begin
          imm_p1_d = sext(imm_i32);
          fmt_p1_d = FMT_I;
        end
      end
      OPC_BRANCH: begin
        if (f3 == 3'b010 || f3 == 3'b011) ill_p1_d = 1'b1;
        else begin
          imm_p1_d    = sext(imm_b32);
          fmt_p1_d    = FMT_B;
          tgt_en_p1_d = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (f3 == 3'b111 || (!IS64 && (f3 == 3'b011 || f3 == 3'b110))) ill_p1_d = 1'b1;
        else begin
          imm_p1_d = sext(imm_i32);
          fmt_p1_d = FMT_I;
        end
      end
      OPC_STORE: begin
        if (f3[2] || (!IS64 && f3 == 3'b011)) ill_p1_d = 1'b1;
        else begin
          imm_p1_d = sext(imm_s32);
          fmt_p1_d = FMT_S;
        end
      end
      OPC_OPIMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          if (shift_bad(instr[31:25], f3[2], IS64)) ill_p1_d = 1'b1;
          else begin
            imm_p1_d = IS64 ? shamt6 : shamt5;
            fmt_p1_d = FMT_SHAMT;
          end
        end else begin
          imm_p1_d = sext(imm_i32);
          fmt_p1_d = FMT_I;
        end
      end
      OPC_OP, OPC_MISC: begin
      end
      OPC_SYSTEM: begin
`ifdef IMMGEN_CSR_EN
        if (f3[2] && f3[1:0] != 2'b00) begin
          imm_p1_d = XLEN'(instr[19:15]);
          fmt_p1_d = FMT_CSR;
        end
`endif
      end
      OPC_OPIMM32: begin
        if (!IS64) ill_p1_d = 1'b1;
        else if (f3 == 3'b000) begin
          imm_p1_d = sext(imm_i32);
          fmt_p1_d = FMT_I;
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
          if (shift_bad(instr[31:25], f3[2], 1'b0)) ill_p1_d = 1'b1;
          else begin
            imm_p1_d = shamt5;
            fmt_p1_d = FMT_SHAMT;
          end
        end else ill_p1_d = 1'b1;
      end
      OPC_OP32: begin
        if (!IS64) ill_p1_d = 1'b1;
      end
      default: ill_p1_d = 1'b1;
    endcase
  end

  // ---- stage 1 boundary: decoded fields ----
  always_ff @(posedge clk) begin
    if (s1_ready && bus.in_valid) begin
      imm_p1_q    <= imm_p1_d;
      fmt_p1_q    <= fmt_p1_d;
      ill_p1_q    <= ill_p1_d;
      tgt_en_p1_q <= tgt_en_p1_d;
      pc_p1_q     <= bus.in_pc;
    end
  end

  assign tgt_p2_d = tgt_en_p1_q ? pc_p1_q + imm_p1_q : '0;

  // ---- stage 2 boundary: target plus carried fields (drives outputs) ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      imm_p2_q <= '0;
      fmt_p2_q <= FMT_R;
      ill_p2_q <= 1'b0;
      pc_p2_q  <= '0;
      tgt_p2_q <= '0;
    end else begin
      if (s1_ready) vld_p1_q <= bus.in_valid;
      if (s2_ready) vld_p2_q <= vld_p1_q;
      if (s2_ready && vld_p1_q) begin
        imm_p2_q <= imm_p1_q;
        fmt_p2_q <= fmt_p1_q;
        ill_p2_q <= ill_p1_q;
        pc_p2_q  <= pc_p1_q;
        tgt_p2_q <= tgt_p2_d;
      end
    end
  end

  assign bus.in_ready    = s1_ready;
  assign bus.out_valid   = vld_p2_q;
  assign bus.out_imm     = imm_p2_q;
  assign bus.out_fmt     = fmt_p2_q;
  assign bus.out_target  = tgt_p2_q;
  assign bus.out_illegal = ill_p2_q;
  assign bus.out_pc      = pc_p2_q;

endmodule

// File: tb/tb_immgen_pipe.sv
module tb_immgen_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  immgen_if #(.XLEN(32)) b32 ();
  immgen_if #(.XLEN(64)) b64 ();

  immgen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  immgen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [31:0] imm32;
    logic [31:0] tgt32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [63:0] tgt64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pc);
    b32.in_valid = v; b32.in_instr = instr; b32.in_pc = pc[31:0];
    b64.in_valid = v; b64.in_instr = instr; b64.in_pc = pc;
  endtask

  task automatic set_ready(input logic r);
    b32.out_ready = r;
    b64.out_ready = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input int k);
    vec_t v;
    v = vt[k];
    check($sformatf("v%0d valid32", k), 64'(b32.out_valid), 64'd1);
    check($sformatf("v%0d imm32", k), 64'(b32.out_imm), 64'(v.imm32));
    check($sformatf("v%0d fmt32", k), 64'(b32.out_fmt), 64'(v.fmt32));
    check($sformatf("v%0d tgt32", k), 64'(b32.out_target), 64'(v.tgt32));
    check($sformatf("v%0d ill32", k), 64'(b32.out_illegal), 64'(v.ill32));
    check($sformatf("v%0d pc32", k), 64'(b32.out_pc), 64'(v.pc[31:0]));
    check($sformatf("v%0d valid64", k), 64'(b64.out_valid), 64'd1);
    check($sformatf("v%0d imm64", k), b64.out_imm, v.imm64);
    check($sformatf("v%0d fmt64", k), 64'(b64.out_fmt), 64'(v.fmt64));
    check($sformatf("v%0d tgt64", k), b64.out_target, v.tgt64);
    check($sformatf("v%0d ill64", k), 64'(b64.out_illegal), 64'(v.ill64));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " valid"}, 64'(b32.out_valid), 64'd0);
    check({tag, " imm"}, 64'(b32.out_imm), 64'd0);
    check({tag, " fmt"}, 64'(b32.out_fmt), 64'd0);
    check({tag, " target"}, 64'(b32.out_target), 64'd0);
    check({tag, " illegal"}, 64'(b32.out_illegal), 64'd0);
    check({tag, " pc"}, 64'(b32.out_pc), 64'd0);
    check({tag, " in_ready"}, 64'(b32.in_ready), 64'd1);
    check({tag, " valid64"}, 64'(b64.out_valid), 64'd0);
    check({tag, " target64"}, b64.out_target, 64'd0);
    check({tag, " in_ready64"}, 64'(b64.in_ready), 64'd1);
  endtask

  logic [31:0] csr_imm;
  logic [2:0]  csr_fmt;
  logic [31:0] seq_instr [4];
  logic [31:0] hold_imm, hold_pc;
  logic        held;
  int          idx, oidx;

  initial begin
`ifdef IMMGEN_CSR_EN
    csr_imm = 32'd5; csr_fmt = 3'd7;
`else
    csr_imm = 32'd0; csr_fmt = 3'd0;
`endif
    //          instr         pc         imm32         tgt32   f32 i32 imm64                  tgt64   f64 i64
    vt[0]  = '{32'hFFF00093, 64'h0,    32'hFFFFFFFF, 32'h0,  3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0,  3'd1, 1'b0};
    vt[1]  = '{32'hFFDFF06F, 64'h100,  32'hFFFFFFFC, 32'hFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'hFC, 3'd5, 1'b0};
    vt[2]  = '{32'h4030D093, 64'h0,    32'h3,        32'h0,  3'd6, 1'b0, 64'h3,                64'h0,  3'd6, 1'b0};
    vt[3]  = '{32'h02009093, 64'h0,    32'h0,        32'h0,  3'd0, 1'b1, 64'h20,               64'h0,  3'd6, 1'b0};
    vt[4]  = '{32'h12345037, 64'h200,  32'h12345000, 32'h0,  3'd4, 1'b0, 64'h12345000,         64'h0,  3'd4, 1'b0};
    vt[5]  = '{32'hFFFFF017, 64'h3000, 32'hFFFFF000, 32'h2000, 3'd4, 1'b0, 64'hFFFFFFFFFFFFF000, 64'h2000, 3'd4, 1'b0};
    vt[6]  = '{32'h00000463, 64'h40,   32'h8,        32'h48, 3'd3, 1'b0, 64'h8,                64'h48, 3'd3, 1'b0};
    vt[7]  = '{32'hFE0018E3, 64'h100,  32'hFFFFFFF0, 32'hF0, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF0, 64'hF0, 3'd3, 1'b0};
    vt[8]  = '{32'h00002063, 64'h100,  32'h0,        32'h0,  3'd0, 1'b1, 64'h0,                64'h0,  3'd0, 1'b1};
    vt[9]  = '{32'hFE112E23, 64'h0,    32'hFFFFFFFC, 32'h0,  3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0,  3'd2, 1'b0};
    vt[10] = '{32'h00003023, 64'h0,    32'h0,        32'h0,  3'd0, 1'b1, 64'h0,                64'h0,  3'd2, 1'b0};
    vt[11] = '{32'h00803003, 64'h0,    32'h0,        32'h0,  3'd0, 1'b1, 64'h8,                64'h0,  3'd1, 1'b0};
    vt[12] = '{32'h7FF02083, 64'h0,    32'h7FF,      32'h0,  3'd1, 1'b0, 64'h7FF,              64'h0,  3'd1, 1'b0};
    vt[13] = '{32'h800280E7, 64'h500,  32'hFFFFF800, 32'h0,  3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 64'h0,  3'd1, 1'b0};
    vt[14] = '{32'h00001067, 64'h0,    32'h0,        32'h0,  3'd0, 1'b1, 64'h0,                64'h0,  3'd0, 1'b1};
    vt[15] = '{32'h002081B3, 64'h0,    32'h0,        32'h0,  3'd0, 1'b0, 64'h0,                64'h0,  3'd0, 1'b0};
    vt[16] = '{32'h0FF0000F, 64'h0,    32'h0,        32'h0,  3'd0, 1'b0, 64'h0,                64'h0,  3'd0, 1'b0};
    vt[17] = '{32'h3002D073, 64'h0,    csr_imm,      32'h0,  csr_fmt, 1'b0, 64'(csr_imm),      64'h0,  csr_fmt, 1'b0};
    vt[18] = '{32'h0000007F, 64'h0,    32'h0,        32'h0,  3'd0, 1'b1, 64'h0,                64'h0,  3'd0, 1'b1};
    vt[19] = '{32'hFFF0809B, 64'h0,    32'h0,        32'h0,  3'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h0,  3'd1, 1'b0};
    vt[20] = '{32'h0200909B, 64'h0,    32'h0,        32'h0,  3'd0, 1'b1, 64'h0,                64'h0,  3'd0, 1'b1};
    vt[21] = '{32'h4030D09B, 64'h0,    32'h0,        32'h0,  3'd0, 1'b1, 64'h3,                64'h0,  3'd6, 1'b0};
    vt[22] = '{32'h8000D093, 64'h0,    32'h0,        32'h0,  3'd0, 1'b1, 64'h0,                64'h0,  3'd0, 1'b1};
    vt[23] = '{32'h01F09093, 64'h0,    32'h1F,       32'h0,  3'd6, 1'b0, 64'h1F,               64'h0,  3'd6, 1'b0};
    vt[24] = '{32'h002081BB, 64'h0,    32'h0,        32'h0,  3'd0, 1'b1, 64'h0,                64'h0,  3'd0, 1'b0};
    vt[25] = '{32'h00000073, 64'h0,    32'h0,        32'h0,  3'd0, 1'b0, 64'h0,                64'h0,  3'd0, 1'b0};
    vt[26] = '{32'h4210D093, 64'h0,    32'h0,        32'h0,  3'd0, 1'b1, 64'h21,               64'h0,  3'd6, 1'b0};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    set_ready(1'b1);
    tick;
    tick;
    rst_n = 1'b1;
    check_reset_outputs("reset");

    // Table: one vector per cycle, result due two cycles after it is presented
    for (int i = 0; i < NV + 2; i++) begin
      if (i == 1) check("latency not early", 64'(b32.out_valid), 64'd0);
      if (i >= 2) check_vec(i - 2);
      if (i < NV) drive(1'b1, vt[i].instr, vt[i].pc);
      else        drive(1'b0, 32'h0, 64'h0);
      tick;
    end
    check("drain no extra output", 64'(b32.out_valid), 64'd0);

    // Backpressure: 4 back-to-back instrs, out_ready low in cycles 2..4
    for (int k = 0; k < 4; k++) seq_instr[k] = {12'(5 + k), 5'd0, 3'd0, 5'd1, 7'h13};
    idx = 0; oidx = 0; held = 1'b0; hold_imm = '0; hold_pc = '0;
    for (int c = 0; c < 30; c++) begin
      set_ready(!(c >= 2 && c <= 4));
      if (idx < 4) drive(1'b1, seq_instr[idx], 64'(32'h1000 + 32'(4 * idx)));
      else         drive(1'b0, 32'h0, 64'h0);
      @(negedge clk);
      if (c == 2) begin
        check("bp in_ready low", 64'(b32.in_ready), 64'd0);
        check("bp stalled valid", 64'(b32.out_valid), 64'd1);
      end
      if (b32.out_valid && !b32.out_ready) begin
        if (held) begin
          check("bp hold imm", 64'(b32.out_imm), 64'(hold_imm));
          check("bp hold pc", 64'(b32.out_pc), 64'(hold_pc));
        end
        held = 1'b1;
        hold_imm = b32.out_imm;
        hold_pc = b32.out_pc;
      end else held = 1'b0;
      if (b32.out_valid && b32.out_ready) begin
        if (oidx < 4) begin
          check($sformatf("bp order imm %0d", oidx), 64'(b32.out_imm), 64'(5 + oidx));
          check($sformatf("bp order pc %0d", oidx), 64'(b32.out_pc), 64'(32'h1000 + 32'(4 * oidx)));
        end
        oidx++;
      end
      if (b32.in_valid && b32.in_ready) idx++;
      @(posedge clk);
      #1;
    end
    check("bp all accepted", 64'(idx), 64'd4);
    check("bp outputs emerged", 64'(oidx), 64'd4);

    // Reset with both stages full
    set_ready(1'b0);
    drive(1'b1, 32'hFFDFF06F, 64'h100);
    tick;
    drive(1'b1, 32'h7FF02083, 64'h200);
    tick;
    drive(1'b0, 32'h0, 64'h0);
    check("full in_ready low", 64'(b32.in_ready), 64'd0);
    check("full out_target", 64'(b32.out_target), 64'hFC);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    set_ready(1'b1);
    tick;
    tick;
    check("midrst discarded", 64'(b32.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
